// File: rtl/mult_div_seq_if.sv
// ----------------------------------------------------------------------------
// mult_div_seq_if
// Request/response bundle for the sequential multiply/divide unit.
//   in_valid/in_ready : request handshake (op, a, b travel with in_valid)
//   op                : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b              : multiplicand/dividend, multiplier/divisor
//   flush             : abandon any in-flight or pending result
//   out_valid/out_ready : result handshake
//   hi, lo            : product upper/lower half, or remainder/quotient
// master = requester/consumer side, slave = the arithmetic unit.
// ----------------------------------------------------------------------------
interface mult_div_seq_if #(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, hi, lo
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, hi, lo
    );
endinterface

// File: rtl/mult_div_seq.sv
// ----------------------------------------------------------------------------
// mult_div_seq
// Iterative radix-2 multiply/divide unit. One request at a time: a multiply
// runs WIDTH shift-add steps, a divide runs WIDTH restoring steps, both on
// operand magnitudes. Sign correction is folded into the last step so the
// result lands in DONE WIDTH+1 cycles after the accept cycle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears state, counter and hi/lo
//   bus   : mult_div_seq_if.slave (request, flush and result handshake)
// ----------------------------------------------------------------------------
module mult_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    mult_div_seq_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi_r, lo_r;

    // Working registers: opnd holds |multiplicand| or |divisor|; work_hi is
    // the partial product / partial remainder; work_lo is the multiplier
    // being consumed / dividend being shifted out while quotient bits enter.
    logic [WIDTH-1:0] opnd, work_hi, work_lo;
    logic             q_neg, r_neg, dbz;

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    logic             accept, last_step;
    logic             a_neg_in, b_neg_in;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign accept    = bus.in_valid && (state == S_IDLE) && !bus.flush;
    assign last_step = (cnt == LAST);
    assign a_neg_in  = bus.op[0] && bus.a[WIDTH-1];
    assign b_neg_in  = bus.op[0] && bus.b[WIDTH-1];
    assign abs_a     = cond_neg(bus.a, a_neg_in);
    assign abs_b     = cond_neg(bus.b, b_neg_in);

    // Shift-add step: add multiplicand when the current multiplier bit is set,
    // then shift the (WIDTH+1)-bit sum and the multiplier right together.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

    assign mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], work_lo[WIDTH-1:1]};

    // Restoring step: the partial remainder is always below the divisor, so
    // the subtraction result fits in WIDTH bits whenever it is kept.
    logic [WIDTH:0]   div_sh;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff, div_hi_n, div_lo_n;

    assign div_sh   = {work_hi, work_lo[WIDTH-1]};
    assign div_ge   = (div_sh >= {1'b0, opnd});
    assign div_diff = div_sh[WIDTH-1:0] - opnd;
    assign div_hi_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
    assign div_lo_n = {work_lo[WIDTH-2:0], div_ge};

    // Result of the final step with sign correction. A zero divisor makes
    // every restoring step succeed: the quotient becomes all ones and the
    // remainder |a|, which re-signed gives back a. MIN / -1 needs no special
    // case: |MIN| / 1 re-signed positive is bit-identical to a.
    logic [WIDTH-1:0] fin_hi, fin_lo;

    always_comb begin
        fin_hi = '0;
        fin_lo = '0;
        if (state == S_MUL) begin
            {fin_hi, fin_lo} = cond_neg2({mul_hi_n, mul_lo_n}, q_neg);
        end else begin
            fin_hi = cond_neg(div_hi_n, r_neg);
            fin_lo = dbz ? '1 : cond_neg(div_lo_n, q_neg);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_r  <= '0;
            lo_r  <= '0;
        end else if (bus.flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state <= bus.op[1] ? S_DIV : S_MUL;
                        cnt   <= '0;
                    end
                end
                S_MUL, S_DIV: begin
                    if (last_step) begin
                        state <= S_DONE;
                        cnt   <= '0;
                        hi_r  <= fin_hi;
                        lo_r  <= fin_lo;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            opnd    <= bus.op[1] ? abs_b : abs_a;
            work_hi <= '0;
            work_lo <= bus.op[1] ? abs_a : abs_b;
            q_neg   <= a_neg_in ^ b_neg_in;
            r_neg   <= a_neg_in;
            dbz     <= bus.op[1] && (bus.b == '0);
        end else if (state == S_MUL) begin
            work_hi <= mul_hi_n;
            work_lo <= mul_lo_n;
        end else if (state == S_DIV) begin
            work_hi <= div_hi_n;
            work_lo <= div_lo_n;
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.hi        = hi_r;
    assign bus.lo        = lo_r;
endmodule

// File: tb/tb_mult_div_seq.sv
module tb_mult_div_seq;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mult_div_seq_if #(.WIDTH(W)) bus ();

    mult_div_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the operands, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: res = {32'b0, a} * {32'b0, b};
            2'd1: res = 64'(sa * sb);
            2'd2: res = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    // Called on a falling edge while idle; returns on a falling edge while idle.
    task automatic run_op(input logic [1:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          input logic [63:0] exp, input int hold, input string name);
        int lat;
        int waitc;
        waitc = 0;
        while (!bus.in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        check({name, " in_ready_before"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid  = 1'b1;
        bus.op        = op_i;
        bus.a         = a_i;
        bus.b         = b_i;
        bus.out_ready = (hold == 0);
        @(negedge clk);
        // Scramble inputs after the accept edge; the captured operands must win.
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom_range(0, 3));
        bus.a        = $urandom;
        bus.b        = $urandom;
        lat = 1;
        while (!bus.out_valid && lat < W + 10) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'(W + 1));
        for (int i = 0; i <= hold; i++) begin
            check({name, " out_valid"}, 64'(bus.out_valid), 64'd1);
            check({name, " hi"}, 64'(bus.hi), 64'(exp[63:32]));
            check({name, " lo"}, 64'(bus.lo), 64'(exp[31:0]));
            check({name, " in_ready_busy"}, 64'(bus.in_ready), 64'd0);
            if (i == hold) bus.out_ready = 1'b1;
            @(negedge clk);
        end
        check({name, " out_valid_drop"}, 64'(bus.out_valid), 64'd0);
        check({name, " in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    task automatic watch_no_valid(input string name, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check({name, " no_out_valid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [63:0] last_res;
        logic [1:0]  rop;
        logic [W-1:0] ra, rb;
        int sel;

        vecs[0]  = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[1]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[4]  = '{2'd2, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
        vecs[5]  = '{2'd2, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[6]  = '{2'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
        vecs[7]  = '{2'd3, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[8]  = '{2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[9]  = '{2'd1, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[10] = '{2'd0, 32'd0,         32'h1234_5678, 32'd0,         32'd0};
        vecs[11] = '{2'd2, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[12] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);

        // Directed vectors
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, 0,
                   $sformatf("vec%0d", i));
        end
        last_res = {vecs[12].hi, vecs[12].lo};

        // Flush in IDLE together with in_valid: nothing is accepted
        bus.in_valid = 1'b1;
        bus.op       = 2'd0;
        bus.a        = 32'd9;
        bus.b        = 32'd9;
        bus.flush    = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        check("flush_blocks_accept in_ready", 64'(bus.in_ready), 64'd1);

        // Flush in cycle T+10 of a DIV
        bus.in_valid = 1'b1;
        bus.op       = 2'd3;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush in_ready", 64'(bus.in_ready), 64'd1);
        check("flush out_valid", 64'(bus.out_valid), 64'd0);
        check("flush retained hi", 64'(bus.hi), 64'(last_res[63:32]));
        check("flush retained lo", 64'(bus.lo), 64'(last_res[31:0]));
        watch_no_valid("flush", W + 8);
        run_op(2'd0, 32'd3, 32'd5, {32'd0, 32'd15}, 0, "flush_then_multu");

        // Back-pressure: out_ready low for 5 cycles
        run_op(2'd0, 32'd12345, 32'd6789, model(2'd0, 32'd12345, 32'd6789), 5, "backpressure");

        // Reset mid-MUL
        bus.in_valid = 1'b1;
        bus.op       = 2'd1;
        bus.a        = 32'hFFFF_FFFF;
        bus.b        = 32'd2;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_mid out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_mid in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_mid hi", 64'(bus.hi), 64'd0);
        check("reset_mid lo", 64'(bus.lo), 64'd0);
        watch_no_valid("reset_mid", W + 8);

        // Randomized operations against the reference model
        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) rb = '1;
            if (sel == 2) ra = 32'h8000_0000;
            if (sel == 3) rb = 32'($urandom_range(1, 15));
            run_op(rop, ra, rb, model(rop, ra, rb), $urandom_range(0, 2),
                   $sformatf("rand%0d op%0d a=%0h b=%0h", n, rop, ra, rb));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mult_div_seq.md
MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; legal values are 4..64, even.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  request present.
REQ-005 The block SHALL have port in_ready  output  1  block can accept a request.
REQ-006 The block SHALL have port op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-007 The block SHALL have port a  input  WIDTH  multiplicand / dividend.
REQ-008 The block SHALL have port b  input  WIDTH  multiplier / divisor.
REQ-009 The block SHALL have port flush  input  1  abandon any in-flight or pending result.
REQ-010 The block SHALL have port out_valid  output  1  hi/lo hold a completed result.
REQ-011 The block SHALL have port out_ready  input  1  consumer takes result.
REQ-012 The block SHALL have port hi  output  WIDTH  product upper half / remainder.
REQ-013 The block SHALL have port lo  output  WIDTH  product lower half / quotient.

Function
REQ-014 The block SHALL implement states IDLE, MUL, DIV, DONE; in_ready SHALL equal (state==IDLE), out_valid SHALL equal (state==DONE).
REQ-015 Accept occurs on a rising edge with in_valid && in_ready && !flush; op, a, b SHALL be captured at that edge and later input changes SHALL be ignored.
REQ-016 On accept, the next state SHALL be MUL for op[1]==0 and DIV for op[1]==1.
REQ-017 MUL and DIV SHALL each iterate exactly WIDTH cycles: one radix-2 step per cycle; shift-add for MUL, restoring for DIV.
REQ-018 out_valid SHALL first assert in cycle T+WIDTH+1, where T is the accept cycle; throughput is at most one op per WIDTH+2 cycles.
REQ-019 Signed ops SHALL iterate on operand magnitudes and apply the sign correction on the transition into DONE, adding no extra cycle.
REQ-020 MULTU: {hi,lo} SHALL equal the unsigned 2*WIDTH-bit product a*b.
REQ-021 MULT: {hi,lo} SHALL equal the two's-complement 2*WIDTH-bit product a*b.
REQ-022 DIVU: lo SHALL equal floor(a/b) and hi SHALL equal a mod b.
REQ-023 DIV: lo SHALL equal the quotient truncated toward zero, and hi SHALL equal the remainder with the sign of a (hi==0 allowed), so that a == lo*b + hi.
REQ-024 For a divide by zero (b==0, DIVU or DIV), lo SHALL be all ones and hi SHALL be a; latency SHALL be unchanged.
REQ-025 For signed overflow (DIV, a==most-negative, b==all ones), lo SHALL be a and hi SHALL be 0.
REQ-026 In DONE, hi/lo SHALL be stable; the block SHALL leave DONE for IDLE on an edge with out_ready==1.
REQ-027 Accept SHALL NOT occur in the DONE->IDLE cycle, since in_ready is low in DONE.
REQ-028 While out_valid is high with out_ready low, the block SHALL hold DONE indefinitely.
REQ-029 flush==1 at an edge SHALL force IDLE from any state, discard the result and block any accept in that cycle; flush has priority over in_valid and out_ready.
REQ-030 In IDLE, hi/lo SHALL retain the last completed result; values produced while out_valid==0 are don't-care to consumers.
REQ-031 Internal iteration counter SHALL be ceil(log2(WIDTH+1)) bits and SHALL never wrap during an op.

Reset
REQ-032 reset==1 at an edge SHALL force state IDLE, hi=0, lo=0, counter=0, with out_valid=0 and in_ready=1 in the following cycle.
REQ-033 reset SHALL have priority over flush, in_valid and out_ready, and SHALL abort a MUL/DIV mid-iteration with no result emitted.

Verification
REQ-034 WIDTH=32, MULT a=0xFFFFFFFF (-1), b=0x00000002, out_ready=1 -> out_valid in cycle T+33, hi=0xFFFFFFFF, lo=0xFFFFFFFE, single-cycle pulse.
REQ-035 WIDTH=32, MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-036 WIDTH=32, DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 WIDTH=32, DIVU a=0x12345678, b=0 -> lo=0xFFFFFFFF, hi=0x12345678 at T+33.
REQ-038 Flush asserted in cycle T+10 of a DIV -> in_ready=1 in cycle T+11, out_valid never asserts; a MULTU 3*5 accepted next -> hi=0, lo=15.
REQ-039 out_ready held 0 for 5 cycles after out_valid -> out_valid and hi/lo stable for 6 cycles, in_ready=0 throughout; reset asserted mid-MUL -> out_valid=0, in_ready=1, hi=lo=0 in the next cycle.
